niu_rx_multi_filter: RTL



---
 rtl/niu_rx_multi_filter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/niu_rx_multi_filter.sv
// Store-and-forward MAC RX filter: drops frames by destination MAC, tuser error or lack of buffer space.
// Define NIU_RX_STATS_EN to add the 32-bit frame counters stat_ok_cnt / stat_ovf_cnt / stat_flt_cnt.
module niu_rx_multi_filter #(
    parameter int DATA_W  = 64,
    parameter int NUM_MAC = 4,
    parameter int DEPTH   = 512
) (
    input  logic                  clk156,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  filter_en,
    input  logic [NUM_MAC*48-1:0] mac_id_tbl,
    input  logic [NUM_MAC-1:0]    mac_id_vld,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  rx_overflow,
    output logic                  rx_filtered
`ifdef NIU_RX_STATS_EN
    ,
    output logic [31:0]           stat_ok_cnt,
    output logic [31:0]           stat_ovf_cnt,
    output logic [31:0]           stat_flt_cnt
`endif
);

    localparam int KW = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = DATA_W + KW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [WW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_spec;
    logic [PW-1:0] wr_cmt;
    logic [PW-1:0] rd_ptr;
    logic          in_frame;
    logic          drop_flt_q;
    logic          drop_ovf_q;

    logic [47:0]   dst_mac;
    logic          mac_hit;
    logic          sof;
    logic          full;
    logic          drop_flt;
    logic          drop_ovf;
    logic          drop;
    logic          eof;
    logic          wr_en;
    logic          commit;
    logic          avail;
    logic          load;
    logic [WW-1:0] rd_word;

    // Octet 0 of the frame sits in tdata[7:0]; table entries hold the first octet in bits [47:40].
    always_comb begin
        dst_mac = '0;
        for (int b = 0; b < 6; b++) begin
            dst_mac[47-8*b -: 8] = s_axis_tdata[8*b +: 8];
        end
        mac_hit = (dst_mac == 48'hFFFF_FFFF_FFFF);
        for (int i = 0; i < NUM_MAC; i++) begin
            if (mac_id_vld[i] && (mac_id_tbl[48*i +: 48] == dst_mac)) begin
                mac_hit = 1'b1;
            end
        end
    end

    // Filter inputs only matter on the SOF beat; afterwards the latched verdict is used.
    assign sof      = !in_frame;
    assign full     = ((wr_spec - rd_ptr) == FULL_LVL);
    assign drop_flt = sof ? (filter_en && !mac_hit) : drop_flt_q;
    assign drop_ovf = drop_ovf_q || full;
    assign drop     = drop_flt || drop_ovf || (s_axis_tlast && s_axis_tuser);
    assign eof      = s_axis_tvalid && s_axis_tlast;
    assign wr_en    = s_axis_tvalid && !drop;
    assign commit   = eof && !drop;

    assign rx_overflow = !reset && eof && drop_ovf;
    assign rx_filtered = !reset && eof && drop && !drop_ovf;

    always_ff @(posedge clk156) begin
        if (reset) begin
            wr_spec    <= '0;
            wr_cmt     <= '0;
            in_frame   <= 1'b0;
            drop_flt_q <= 1'b0;
            drop_ovf_q <= 1'b0;
        end else if (s_axis_tvalid) begin
            in_frame   <= !s_axis_tlast;
            drop_flt_q <= !s_axis_tlast && drop_flt;
            drop_ovf_q <= !s_axis_tlast && drop_ovf;
            // A dropped beat rewinds the speculative pointer, releasing the partial frame at once.
            wr_spec    <= drop ? wr_cmt : wr_spec + PW'(1);
            if (commit) begin
                wr_cmt <= wr_spec + PW'(1);
            end
        end
    end

    // NOTE: the buffer array carries no reset; only the pointers define which words are valid.
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    assign avail   = (wr_cmt != rd_ptr);
    assign load    = avail && (!m_axis_tvalid || m_axis_tready);
    assign rd_word = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk156) begin
        if (reset) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_word;
            m_axis_tvalid <= 1'b1;
            rd_ptr        <= rd_ptr + PW'(1);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef NIU_RX_STATS_EN
    always_ff @(posedge clk156) begin
        if (reset) begin
            stat_ok_cnt  <= '0;
            stat_ovf_cnt <= '0;
            stat_flt_cnt <= '0;
        end else begin
            if (commit)      stat_ok_cnt  <= stat_ok_cnt + 32'd1;
            if (rx_overflow) stat_ovf_cnt <= stat_ovf_cnt + 32'd1;
            if (rx_filtered) stat_flt_cnt <= stat_flt_cnt + 32'd1;
        end
    end
`endif

endmodule
